die_roll_ctrl: RTL

Front-end roll controller for the six-sided die. It sits upstream of the die top-level and downstream of the LFSR.
- Conditions the raw roll switch: synchronises it, debounces it, then enforces a minimum spin time.
- Converts the 8-bit LFSR byte into an unbiased face value 1..6 using rejection sampling with a bounded fallback.
- Presents a stable face plus valid/done flags to the seven-segment stage.

---
 rtl/die_roll_if.sv | 13 +
 rtl/die_roll_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/die_roll_if.sv
// Roll controller bus: switch and LFSR byte in, face and status flags out.
// master = stimulus side (switch/LFSR), slave = die_roll_ctrl.
interface die_roll_if;
    logic       sw_raw;
    logic [7:0] rand_in;
    logic [2:0] face;
    logic       face_valid;
    logic       rolling;
    logic       roll_done;

    modport master (output sw_raw, rand_in, input face, face_valid, rolling, roll_done);
    modport slave  (input sw_raw, rand_in, output face, face_valid, rolling, roll_done);
endinterface

// File: rtl/die_roll_ctrl.sv
// Die roll front-end: switch sync/debounce, timed spin, rejection-sampled face 1..6.
// Optional macro ROLL_ANIM_EN: tumbling face display during SPIN.
module die_roll_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SPIN_CYCLES     = 64,
    parameter int SETTLE_TRIES    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    die_roll_if.slave   bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SPIN_CYCLES + 1);
    localparam int TW = 4;

    typedef enum logic [1:0] {IDLE, SPIN, SETTLE, HOLD} state_t;

    state_t        state, state_d;
    logic          sync1, sw_s, sw_db, sw_db_q;
    logic [DW-1:0] db_cnt;
    logic [SW-1:0] spin_cnt, spin_d;
    logic [TW-1:0] try_cnt, try_d;
    logic [2:0]    face_q, face_d;
    logic          done_q, done_d;

    logic [2:0] cand, fallback;
    logic       accept, db_rise;

    assign cand     = bus.rand_in[2:0];
    assign accept   = (cand != 3'd0) && (cand != 3'd7);
    assign fallback = 3'(bus.rand_in % 8'd6) + 3'd1;
    assign db_rise  = sw_db & ~sw_db_q;

    // Synchroniser and debounce; sw_db only moves after DEBOUNCE_CYCLES stable mismatches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sw_s    <= 1'b0;
            sw_db   <= 1'b0;
            sw_db_q <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1   <= bus.sw_raw;
            sw_s    <= sync1;
            sw_db_q <= sw_db;
            if (sw_s != sw_db) begin
                if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    sw_db  <= sw_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            spin_cnt <= '0;
            try_cnt  <= '0;
            face_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            spin_cnt <= spin_d;
            try_cnt  <= try_d;
            face_q   <= face_d;
            done_q   <= done_d;
        end
    end

    // Switch release is checked first so it wins over spin expiry and settle accept.
    always_comb begin
        state_d = state;
        spin_d  = spin_cnt;
        try_d   = try_cnt;
        face_d  = face_q;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                face_d = '0;
                if (db_rise) begin
                    state_d = SPIN;
                    spin_d  = SW'(SPIN_CYCLES - 1);
                end
            end
            SPIN: begin
                if (!sw_db) begin
                    state_d = IDLE;
                    face_d  = '0;
                end else begin
`ifdef ROLL_ANIM_EN
                    if (accept) face_d = cand;
`else
                    face_d = '0;
`endif
                    if (spin_cnt == '0) begin
                        state_d = SETTLE;
                        try_d   = '0;
                    end else begin
                        spin_d = spin_cnt - SW'(1);
                    end
                end
            end
            SETTLE: begin
                if (!sw_db) begin
                    state_d = IDLE;
                    face_d  = '0;
                end else if (accept) begin
                    state_d = HOLD;
                    face_d  = cand;
                    done_d  = 1'b1;
                end else if (try_cnt == TW'(SETTLE_TRIES - 1)) begin
                    state_d = HOLD;
                    face_d  = fallback;
                    done_d  = 1'b1;
                end else begin
                    try_d = try_cnt + TW'(1);
                end
            end
            HOLD: begin
                if (!sw_db) begin
                    state_d = IDLE;
                    face_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.face       = face_q;
    assign bus.face_valid = (state == HOLD);
    assign bus.rolling    = (state == SPIN) || (state == SETTLE);
    assign bus.roll_done  = done_q;
endmodule
